// File: rtl/intdstagent.sv
// Per-core interrupt destination agent: acknowledges controller requests over the
// memory-mapped port, delivers the retrieved id to the core and mirrors its enable.
module intdstagent #(
  parameter int ARCHBITSZ = 32,
  parameter int DSTID     = 0,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8),
  parameter logic [ADDRBITSZ-1:0] INTCTRLADDR = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic                   pi1_rdy_i,
  input  logic                   intrqstdst_i,
  output logic                   intrdydst_o,
  output logic                   intbestdst_o,
  input  logic                   core_inten_i,
  input  logic                   core_halted_i,
  output logic                   core_intrqst_o,
  output logic [ARCHBITSZ-1:0]   core_intid_o,
  input  logic                   core_intack_i
);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b11;
  localparam logic [ARCHBITSZ-4:0] DST_ID = (ARCHBITSZ-3)'(DSTID);
  localparam logic [ARCHBITSZ-1:0] ID_SWI      = '1;
  localparam logic [ARCHBITSZ-1:0] ID_SPURIOUS = {{(ARCHBITSZ-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, ACKREQ, ACKRSP, ENREQ, ENRSP, DELIVER} state_t;

  state_t               state;
  logic                 ensent;
  logic [ARCHBITSZ-1:0] cmd;

  // en is taken from the core at launch; the registered copy keeps it stable across stalls
  assign cmd          = {DST_ID, core_inten_i, 2'b00};
  assign pi1_addr_o   = INTCTRLADDR;
  assign pi1_sel_o    = '1;
  assign intrdydst_o  = (state == IDLE) && core_inten_i && ensent;
  assign intbestdst_o = intrdydst_o && core_halted_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ensent         <= 1'b0;
      pi1_op_o       <= OP_NOP;
      pi1_data_o     <= '0;
      core_intrqst_o <= 1'b0;
      core_intid_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (intrqstdst_i) begin
            state      <= ACKREQ;
            pi1_op_o   <= OP_RW;
            pi1_data_o <= cmd;
          end else if (core_inten_i != ensent) begin
            state      <= ENREQ;
            pi1_op_o   <= OP_RW;
            pi1_data_o <= cmd;
          end
        end
        ACKREQ, ENREQ: begin
          if (pi1_rdy_i) begin
            ensent     <= pi1_data_o[2];
            pi1_op_o   <= OP_NOP;
            pi1_data_o <= '0;
            state      <= (state == ACKREQ) ? ACKRSP : ENRSP;
          end
        end
        ACKRSP: begin
          if (pi1_rdy_i) begin
            if (pi1_data_i == ID_SPURIOUS) begin
              state <= IDLE;
            end else begin
              // all-ones (software interrupt) passes through unchanged like a source index
              core_intid_o   <= (pi1_data_i == ID_SWI) ? ID_SWI : pi1_data_i;
              core_intrqst_o <= 1'b1;
              state          <= DELIVER;
            end
          end
        end
        ENRSP: begin
          if (pi1_rdy_i) state <= IDLE;
        end
        DELIVER: begin
          if (core_intack_i) begin
            core_intrqst_o <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intdstagent.sv
// Bench for intdstagent: directed scenarios plus a randomized transaction loop whose
// expectations come from cycle-count arithmetic and the command/response rules.
module tb_intdstagent;

  localparam int DST = 2;
  localparam logic [29:0] CADDR = 30'h123;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op;
  logic [29:0] addr;
  logic [31:0] dout;
  logic [31:0] din = '0;
  logic [3:0]  sel;
  logic        rdy = 1'b1;
  logic        irq = 1'b0;
  logic        rdydst, best;
  logic        inten = 1'b0;
  logic        halted = 1'b0;
  logic        cirq;
  logic [31:0] cid;
  logic        cack = 1'b0;

  int vec = 0;
  int err = 0;

  intdstagent #(.ARCHBITSZ(32), .DSTID(DST), .INTCTRLADDR(CADDR)) dut (
    .clk_i(clk), .rst_i(rst),
    .pi1_op_o(op), .pi1_addr_o(addr), .pi1_data_o(dout), .pi1_data_i(din),
    .pi1_sel_o(sel), .pi1_rdy_i(rdy),
    .intrqstdst_i(irq), .intrdydst_o(rdydst), .intbestdst_o(best),
    .core_inten_i(inten), .core_halted_i(halted),
    .core_intrqst_o(cirq), .core_intid_o(cid), .core_intack_i(cack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cmd_word(input logic en);
    cmd_word = (32'(DST) << 3) | (32'(en) << 2);
  endfunction

  // Each "cycle" starts 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inten = 1'b0; halted = 1'b1;
    cyc(); cyc(); #1;
    vec++; if (op !== 2'b00) begin err++; $display("FAIL reset_op: got %0h want 0", op); end
    vec++; if (dout !== 32'h0) begin err++; $display("FAIL reset_data: got %h want 0", dout); end
    vec++; if (cirq !== 1'b0) begin err++; $display("FAIL reset_intrqst: got %b want 0", cirq); end
    vec++; if (cid !== 32'h0) begin err++; $display("FAIL reset_intid: got %h want 0", cid); end
    vec++; if (rdydst !== 1'b0 || best !== 1'b0) begin err++; $display("FAIL reset_rdy_best: got %b%b want 00", rdydst, best); end
    vec++; if (addr !== CADDR || sel !== 4'hf) begin err++; $display("FAIL reset_addr_sel: got %h/%h want %h/f", addr, sel, CADDR); end
    rst = 1'b0;
    cyc(); cyc();
    vec++; if (op !== 2'b00) begin err++; $display("FAIL idle_disabled_op: got %0h want 0", op); end
  endtask

  task automatic test_enable_on_reset();
    rst = 1'b1; inten = 1'b1; halted = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); #1;
    vec++; if (op !== 2'b11 || dout !== 32'h14) begin err++; $display("FAIL en_req: got op %0h data %h want 3/00000014", op, dout); end
    vec++; if (rdydst !== 1'b0) begin err++; $display("FAIL en_req_rdy: got %b want 0", rdydst); end
    cyc();
    vec++; if (op !== 2'b00) begin err++; $display("FAIL en_rsp_op: got %0h want 0", op); end
    cyc(); #1;
    vec++; if (rdydst !== 1'b1 || best !== 1'b1) begin err++; $display("FAIL en_done_rdy: got %b%b want 11", rdydst, best); end
    halted = 1'b0; #1;
    vec++; if (best !== 1'b0) begin err++; $display("FAIL best_not_halted: got %b want 0", best); end
  endtask

  task automatic test_ack();
    cack = 1'b1; cyc(); cack = 1'b0;
    vec++; if (op !== 2'b00 || cirq !== 1'b0) begin err++; $display("FAIL stray_ack: got op %0h irq %b want 0/0", op, cirq); end
    irq = 1'b1; cyc(); irq = 1'b0;
    vec++; if (op !== 2'b11 || dout !== 32'h14) begin err++; $display("FAIL ack_req: got op %0h data %h want 3/00000014", op, dout); end
    cyc();
    vec++; if (op !== 2'b00 || dout !== 32'h0) begin err++; $display("FAIL ack_rsp_op: got op %0h data %h want 0/0", op, dout); end
    din = 32'h5;
    cyc(); #1;
    vec++; if (cirq !== 1'b1 || cid !== 32'h5) begin err++; $display("FAIL ack_deliver: got %b/%h want 1/00000005", cirq, cid); end
    vec++; if (rdydst !== 1'b0) begin err++; $display("FAIL deliver_rdy: got %b want 0", rdydst); end
    cack = 1'b1; cyc(); cack = 1'b0; #1;
    vec++; if (cirq !== 1'b0 || rdydst !== 1'b1) begin err++; $display("FAIL ack_clear: got irq %b rdy %b want 0/1", cirq, rdydst); end
  endtask

  task automatic test_special_ids();
    logic [31:0] rsps [2];
    rsps[0] = 32'hFFFF_FFFF; rsps[1] = 32'hFFFF_FFFE;
    for (int i = 0; i < 2; i++) begin
      irq = 1'b1; cyc(); irq = 1'b0;
      cyc(); din = rsps[i];
      cyc(); #1;
      if (i == 0) begin
        vec++; if (cirq !== 1'b1 || cid !== 32'hFFFF_FFFF) begin err++; $display("FAIL swi_deliver: got %b/%h want 1/ffffffff", cirq, cid); end
        cack = 1'b1; cyc(); cack = 1'b0;
      end else begin
        vec++; if (cirq !== 1'b0 || rdydst !== 1'b1) begin err++; $display("FAIL spurious_drop: got irq %b rdy %b want 0/1", cirq, rdydst); end
      end
    end
  endtask

  task automatic test_stall();
    irq = 1'b1; cyc(); irq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rdy = (k == 3);
      vec++; if (op !== 2'b11 || dout !== 32'h14) begin err++; $display("FAIL stall_hold%0d: got op %0h data %h want 3/00000014", k, op, dout); end
      cyc();
    end
    din = 32'h77;
    vec++; if (op !== 2'b00 || cirq !== 1'b0) begin err++; $display("FAIL stall_rsp: got op %0h irq %b want 0/0", op, cirq); end
    cyc();
    vec++; if (cirq !== 1'b1 || cid !== 32'h77) begin err++; $display("FAIL stall_latency: got %b/%h want 1/00000077", cirq, cid); end
    cack = 1'b1; cyc(); cack = 1'b0;
  endtask

  task automatic test_inten_fall();
    irq = 1'b1; cyc(); irq = 1'b0;
    cyc(); din = 32'h9;
    cyc(); inten = 1'b0;
    cyc(); #1;
    vec++; if (cirq !== 1'b1 || rdydst !== 1'b0) begin err++; $display("FAIL fall_deliver: got irq %b rdy %b want 1/0", cirq, rdydst); end
    cack = 1'b1; cyc(); cack = 1'b0; #1;
    vec++; if (cirq !== 1'b0 || rdydst !== 1'b0) begin err++; $display("FAIL fall_idle: got irq %b rdy %b want 0/0", cirq, rdydst); end
    cyc();
    vec++; if (op !== 2'b11 || dout !== 32'h10) begin err++; $display("FAIL fall_enreq: got op %0h data %h want 3/00000010", op, dout); end
    cyc(); cyc(); cyc(); #1;
    vec++; if (op !== 2'b00 || rdydst !== 1'b0) begin err++; $display("FAIL fall_once: got op %0h rdy %b want 0/0", op, rdydst); end
  endtask

  task automatic test_reset_mid();
    inten = 1'b1;
    cyc(); cyc(); cyc();   // re-enable handshake completes
    irq = 1'b1; cyc(); irq = 1'b0;
    cyc(); rst = 1'b1; din = 32'h99;
    cyc(); #1;
    vec++; if (op !== 2'b00 || dout !== 32'h0 || cirq !== 1'b0 || cid !== 32'h0 || rdydst !== 1'b0) begin
      err++; $display("FAIL midreset: got op %0h data %h irq %b id %h rdy %b want all 0", op, dout, cirq, cid, rdydst); end
    rst = 1'b0;
    cyc();
    vec++; if (op !== 2'b11 || dout !== 32'h14 || cid !== 32'h0) begin err++; $display("FAIL midreset_reissue: got op %0h data %h id %h want 3/00000014/0", op, dout, cid); end
    cyc(); cyc(); #1;
    vec++; if (rdydst !== 1'b1) begin err++; $display("FAIL midreset_ready: got %b want 1", rdydst); end
  endtask

  task automatic test_random();
    logic        m_ensent;
    logic [31:0] rsp, exp_id, exp_cmd;
    int          cls, s, r, a;
    logic        tog;
    m_ensent = inten;
    for (int it = 0; it < 40; it++) begin
      cls = $urandom % 3; s = $urandom_range(0, 3); r = $urandom_range(0, 3);
      a = $urandom_range(0, 2); tog = $urandom_range(0, 1) == 1;
      halted = $urandom_range(0, 1) == 1;
      rsp = (cls == 1) ? 32'hFFFF_FFFF : (cls == 2) ? 32'hFFFF_FFFE : ($urandom & 32'h7FFF_FFFF);
      exp_id = rsp;
      exp_cmd = cmd_word(inten);
      irq = 1'b1; cyc(); irq = 1'b0;
      for (int k = 0; k <= s; k++) begin
        vec++; if (op !== 2'b11 || dout !== exp_cmd) begin err++; $display("FAIL rnd%0d_req: got op %0h data %h want 3/%h", it, op, dout, exp_cmd); end
        if (tog && k == 0) inten = ~inten;
        rdy = (k == s);
        cyc();
      end
      m_ensent = exp_cmd[2];
      for (int k = 0; k <= r; k++) begin
        vec++; if (op !== 2'b00 || cirq !== 1'b0) begin err++; $display("FAIL rnd%0d_rsp: got op %0h irq %b want 0/0", it, op, cirq); end
        rdy = (k == r);
        din = (k == r) ? rsp : $urandom;
        cyc();
      end
      rdy = 1'b1;
      if (cls != 2) begin
        for (int k = 0; k <= a; k++) begin
          vec++; if (cirq !== 1'b1 || cid !== exp_id) begin err++; $display("FAIL rnd%0d_deliver: got %b/%h want 1/%h", it, cirq, cid, exp_id); end
          cack = (k == a);
          cyc();
        end
        cack = 1'b0;
      end
      #1;
      vec++; if (cirq !== 1'b0 || rdydst !== (inten && m_ensent) || best !== (inten && m_ensent && halted)) begin
        err++; $display("FAIL rnd%0d_idle: got irq %b rdy %b best %b want 0/%b/%b", it, cirq, rdydst, best, inten && m_ensent, inten && m_ensent && halted); end
      if (tog) begin
        cyc();
        vec++; if (op !== 2'b11 || dout !== cmd_word(inten)) begin err++; $display("FAIL rnd%0d_enreq: got op %0h data %h want 3/%h", it, op, dout, cmd_word(inten)); end
        cyc(); cyc();
        m_ensent = inten;
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_on_reset();
    test_ack();
    test_special_ids();
    test_stall();
    test_inten_fall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
